// File: rtl/norm_pkg.sv
// norm_pkg: shared state encoding, default widths and helpers for the mantissa normalizer
package norm_pkg;
  typedef enum logic [1:0] {IDLE, NORM, DONE} norm_state_t;
  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF = 8;
  localparam int STEP_DEF = 4;
  function automatic int unsigned min3(input int unsigned a, input int unsigned b, input int unsigned c);
    int unsigned m;
    m = a < b ? a : b;
    return m < c ? m : c;
  endfunction
endpackage

// File: rtl/leading_zero_counter.sv
// leading_zero_counter: combinational priority encoder; an all-zero input yields W
module leading_zero_counter #(
  parameter int W = 24,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  val_i,
  output logic [CW-1:0] cnt_o
);
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++)
      if (val_i[i]) cnt_o = CW'(W - 1 - i);
  end
endmodule

// File: rtl/mantissa_normalizer.sv
// mantissa_normalizer: multi-cycle left-normalizer, at most STEP positions per cycle, exponent floored at 0
module mantissa_normalizer
  import norm_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int STEP = STEP_DEF,
  parameter int LZC_W = $clog2(MANT_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [LZC_W-1:0]  out_shift,
  output logic              out_zero,
  output logic              out_underflow
);
  norm_state_t state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d, mant_sh;
  logic [EXP_W-1:0]  exp_q, exp_d, exp_sh;
  logic [LZC_W-1:0]  shift_q, shift_d, lz, s;
  logic              zero_q, zero_d, uf_q, uf_d;

  leading_zero_counter #(.W(MANT_W)) u_lzc (.val_i(mant_q), .cnt_o(lz));

  assign s = LZC_W'(min3(32'(lz), STEP, 32'(exp_q)));
  assign mant_sh = mant_q << s;
  assign exp_sh = exp_q - EXP_W'(s);

  always_comb begin
    state_d = state_q;
    mant_d = mant_q;
    exp_d = exp_q;
    shift_d = shift_q;
    zero_d = zero_q;
    uf_d = uf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        mant_d = in_mant;
        exp_d = in_mant == '0 ? '0 : in_exp;
        shift_d = '0;
        zero_d = in_mant == '0;
        uf_d = 1'b0;
        state_d = in_mant == '0 ? DONE : NORM;
      end
      NORM: begin
        mant_d = mant_sh;
        exp_d = exp_sh;
        shift_d = shift_q + s;
        if (mant_sh[MANT_W-1] || exp_sh == '0) begin
          state_d = DONE;
          uf_d = !mant_sh[MANT_W-1];
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mant_q <= '0;
      exp_q <= '0;
      shift_q <= '0;
      zero_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q <= mant_d;
      exp_q <= exp_d;
      shift_q <= shift_d;
      zero_q <= zero_d;
      uf_q <= uf_d;
    end
  end

  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_mant = mant_q;
  assign out_exp = exp_q;
  assign out_shift = shift_q;
  assign out_zero = zero_q;
  assign out_underflow = uf_q;
endmodule

// File: tb/tb_mantissa_normalizer.sv
// tb_mantissa_normalizer: scoreboard bench comparing results against a closed-form normalization model
module tb_mantissa_normalizer;
  typedef struct {
    logic [23:0] m;
    logic [7:0]  e;
    logic [4:0]  sh;
    logic        z;
    logic        u;
    int          lat;
  } exp_t;

  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [23:0] in_mant = '0;
  logic [7:0]  in_exp = '0;
  logic        in_ready, out_valid, out_zero, out_underflow;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic [4:0]  out_shift;
  int          n_chk = 0, n_fail = 0;
  exp_t        sb[$];

  mantissa_normalizer #(.MANT_W(24), .EXP_W(8), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_shift(out_shift),
    .out_zero(out_zero), .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  // Total shift is min(lz, exp); cycle count is that spread over STEP=4 per cycle, at least one.
  function automatic exp_t model(input logic [23:0] m, input logic [7:0] e);
    exp_t r;
    int lz, sh;
    lz = 24;
    for (int i = 0; i < 24; i++) if (m[i]) lz = 23 - i;
    if (m == 0) begin
      r.m = '0; r.e = '0; r.sh = '0; r.z = 1; r.u = 0; r.lat = 0;
      return r;
    end
    sh = lz < int'(e) ? lz : int'(e);
    r.m = m << sh;
    r.e = e - 8'(sh);
    r.sh = 5'(sh);
    r.z = 0;
    r.u = lz > int'(e);
    r.lat = sh == 0 ? 1 : (sh + 3) / 4;
    return r;
  endfunction

  task automatic issue(input logic [23:0] m, input logic [7:0] e);
    int w;
    sb.push_back(model(m, e));
    in_mant = m; in_exp = e; in_valid = 1;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL accept_wait: in_ready=%b required 1 (timeout)", in_ready); end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic collect(input string tag);
    int lat;
    exp_t x;
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    n_chk++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s out_valid: got %b required 1 (timeout)", tag, out_valid); end
    n_chk++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL %s scoreboard: got empty required entry", tag); return; end
    x = sb.pop_front();
    n_chk++;
    if (out_mant !== x.m) begin n_fail++; $display("FAIL %s mant: got %h required %h", tag, out_mant, x.m); end
    n_chk++;
    if (out_exp !== x.e) begin n_fail++; $display("FAIL %s exp: got %0d required %0d", tag, out_exp, x.e); end
    n_chk++;
    if (out_shift !== x.sh) begin n_fail++; $display("FAIL %s shift: got %0d required %0d", tag, out_shift, x.sh); end
    n_chk++;
    if (out_zero !== x.z) begin n_fail++; $display("FAIL %s zero: got %b required %b", tag, out_zero, x.z); end
    n_chk++;
    if (out_underflow !== x.u) begin n_fail++; $display("FAIL %s underflow: got %b required %b", tag, out_underflow, x.u); end
    n_chk++;
    if (lat !== x.lat) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", tag, lat, x.lat); end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s release: valid/ready got %b%b required 01", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL reset valid/ready: got %b%b required 01", out_valid, in_ready); end
    n_chk++;
    if ({out_mant, out_exp, out_shift, out_zero, out_underflow} !== '0) begin
      n_fail++; $display("FAIL reset outputs: got %h/%0d/%0d/%b/%b required all 0", out_mant, out_exp, out_shift, out_zero, out_underflow);
    end
  endtask

  task automatic test_directed();
    issue(24'h800000, 8'd100); collect("normalized"); release_out("normalized");
    issue(24'h000001, 8'd100); collect("max_shift"); release_out("max_shift");
    issue(24'h000100, 8'd5); collect("underflow"); release_out("underflow");
    issue(24'h000000, 8'd55); collect("zero"); release_out("zero");
    issue(24'h000100, 8'd0); collect("exp0_uf"); release_out("exp0_uf");
    issue(24'h900000, 8'd0); collect("exp0_msb"); release_out("exp0_msb");
    issue(24'h000100, 8'd15); collect("exact_floor"); release_out("exact_floor");
  endtask

  task automatic test_backpressure();
    logic [36:0] snap;
    issue(24'h000010, 8'd50);
    collect("bp_first");
    sb.push_back(model(24'h400000, 8'd20));
    in_mant = 24'h400000; in_exp = 8'd20; in_valid = 1;
    snap = {out_mant, out_exp, out_shift};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if ({out_valid, in_ready} !== 2'b10 || {out_mant, out_exp, out_shift} !== snap) begin
        n_fail++; $display("FAIL bp_hold: valid/ready %b%b data %h required 10 data %h", out_valid, in_ready, {out_mant, out_exp, out_shift}, snap);
      end
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_idle: valid/ready got %b%b required 01", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 0;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept: in_ready got %b required 0", in_ready); end
    collect("bp_second");
    release_out("bp_second");
  endtask

  task automatic test_reset_mid();
    issue(24'h000001, 8'd100);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    n_chk++;
    if ({out_valid, out_mant, out_exp, out_shift, out_zero, out_underflow} !== '0) begin
      n_fail++; $display("FAIL reset_mid outputs: valid %b data %h/%0d/%0d/%b/%b required all 0", out_valid, out_mant, out_exp, out_shift, out_zero, out_underflow);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_mid release: valid/ready got %b%b required 01", out_valid, in_ready); end
    issue(24'h000300, 8'd40); collect("after_reset"); release_out("after_reset");
  endtask

  task automatic test_back_to_back();
    logic [23:0] m;
    logic [7:0] e;
    for (int i = 0; i < 25; i++) begin
      m = 24'($urandom >> $urandom_range(8, 32));
      e = 8'($urandom_range(0, 30));
      issue(m, e);
      collect("random");
      release_out("random");
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1;
    @(negedge clk);
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
